// File: rtl/stk_ram_ctrl_if.sv
// stk_ram_ctrl_if: command/response handshake bundle for the stack engine.
//   cmd_vld/cmd_op/cmd_dat/cmd_rdy : one command at a time, accepted on vld&rdy
//   rsp_vld/rsp_dat/rsp_err/rsp_rdy: one response per accepted command
// master = requester (drives commands, sinks responses), slave = stack engine.
interface stk_ram_ctrl_if #(
  parameter int W = 32
);
  logic         cmd_vld;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_dat;
  logic         cmd_rdy;
  logic         rsp_vld;
  logic         rsp_rdy;
  logic [W-1:0] rsp_dat;
  logic         rsp_err;

  modport master (
    output cmd_vld, cmd_op, cmd_dat, rsp_rdy,
    input  cmd_rdy, rsp_vld, rsp_dat, rsp_err
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_dat, rsp_rdy,
    output cmd_rdy, rsp_vld, rsp_dat, rsp_err
  );
endinterface

// File: rtl/stk_ram_ctrl.sv
// stk_ram_ctrl: LIFO stack whose storage lives in an external single-port
// synchronous RAM. One command in flight; every accepted command gets exactly
// one response.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   bus (slave)          : command/response handshake (see stk_ram_ctrl_if)
//   ram_en/ram_wen       : RAM strobe / write enable, only in the accept cycle
//   ram_addr/ram_din     : RAM address / write data (0 when idle)
//   ram_dout             : RAM read data, valid the cycle after a read strobe
//   cnt/full/empty       : registered occupancy 0..N and its flags
module stk_ram_ctrl #(
  parameter  int W  = 32,
  parameter  int N  = 256,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  stk_ram_ctrl_if.slave bus,
  output logic          ram_en,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [W-1:0]  ram_din,
  input  logic [W-1:0]  ram_dout,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty
);

  typedef enum logic [1:0] {IDLE, POP_WAIT, RSP} state_t;

  localparam logic [1:0]  OP_PUSH = 2'b01;
  localparam logic [1:0]  OP_POP  = 2'b10;
  localparam logic [1:0]  OP_CLR  = 2'b11;
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(N);

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  dat_q, dat_d;
  logic          err_q, err_d;

  assign cnt   = cnt_q;
  assign full  = (cnt_q == CNT_MAX);
  assign empty = (cnt_q == '0);

  assign bus.cmd_rdy = (state_q == IDLE);
  assign bus.rsp_vld = (state_q == RSP);
  assign bus.rsp_dat = dat_q;
  assign bus.rsp_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    err_d    = err_q;
    ram_en   = 1'b0;
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    unique case (state_q)
      IDLE: if (bus.cmd_vld) begin
        // response fields are fixed at accept; POP overwrites data in POP_WAIT
        dat_d   = '0;
        err_d   = 1'b0;
        state_d = RSP;
        case (bus.cmd_op)
          OP_PUSH: begin
            if (!full) begin
              ram_en   = 1'b1;
              ram_wen  = 1'b1;
              ram_addr = cnt_q[AW-1:0];
              ram_din  = bus.cmd_dat;
              cnt_d    = cnt_q + CNT_ONE;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_POP: begin
            if (!empty) begin
              ram_en   = 1'b1;
              // low AW bits wrap correctly at cnt==N (top entry is N-1)
              ram_addr = cnt_q[AW-1:0] - AW'(1);
              cnt_d    = cnt_q - CNT_ONE;
              state_d  = POP_WAIT;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_CLR:  cnt_d = '0;
          default: err_d = 1'b1;
        endcase
      end
      POP_WAIT: begin
        dat_d   = ram_dout;
        state_d = RSP;
      end
      RSP: if (bus.rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stk_ram_ctrl.sv
module tb_stk_ram_ctrl;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int AW = $clog2(N);

  typedef struct packed {
    logic [W-1:0] dat;
    logic         err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ram_en, ram_wen;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_din;
  logic [W-1:0]  ram_dout = '0;
  logic [AW:0]   cnt;
  logic          full, empty;
  logic [W-1:0]  mem [N];

  int            chk_cnt  = 0;
  int            pass_cnt = 0;
  exp_t          expq [$];
  logic [W-1:0]  model [$];

  stk_ram_ctrl_if #(.W(W)) bif ();

  stk_ram_ctrl #(.W(W), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bif),
    .ram_en   (ram_en),
    .ram_wen  (ram_wen),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .cnt      (cnt),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // single-port synchronous RAM model
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      else         ram_dout      <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // response monitor: pops the scoreboard on every response handshake
  always @(negedge clk) begin
    if (!rst && bif.rsp_vld && bif.rsp_rdy) begin
      if (expq.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("rsp_dat", bif.rsp_dat, e.dat);
        chk("rsp_err", bif.rsp_err, e.err);
      end
    end
  end

  // RAM strobe is only legal in an accept cycle
  always @(negedge clk) begin
    if (ram_en) chk("ram_en_only_accept", bif.cmd_vld && bif.cmd_rdy, 1);
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] dat, input int bp);
    logic [W-1:0] edat, d0;
    logic         eerr, e0;
    int           elat, lat;
    bit           ok;
    @(posedge clk); #1;
    bif.cmd_vld = 1'b1; bif.cmd_op = op; bif.cmd_dat = dat; bif.rsp_rdy = (bp == 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.cmd_rdy) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("cmd_rdy_timeout", 0, 1);
      bif.cmd_vld = 1'b0;
      return;
    end
    edat = '0; eerr = 1'b0; elat = 1;
    case (op)
      2'b01: if (model.size() == N) eerr = 1'b1;
             else begin
               chk("push_ram_en", ram_en, 1);
               chk("push_ram_wen", ram_wen, 1);
               chk("push_ram_addr", ram_addr, model.size());
               chk("push_ram_din", ram_din, dat);
               model.push_back(dat);
             end
      2'b10: if (model.size() == 0) eerr = 1'b1;
             else begin
               chk("pop_ram_en", ram_en, 1);
               chk("pop_ram_wen", ram_wen, 0);
               chk("pop_ram_addr", ram_addr, model.size() - 1);
               edat = model.pop_back();
               elat = 2;
             end
      2'b11: model.delete();
      default: eerr = 1'b1;
    endcase
    if (eerr || op == 2'b11) chk("no_ram_access", ram_en, 0);
    expq.push_back({edat, eerr});
    @(posedge clk); #1;
    bif.cmd_vld = 1'b0;
    lat = 0; ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("cnt", cnt, model.size());
        chk("full", full, model.size() == N);
        chk("empty", empty, model.size() == 0);
      end
      if (bif.rsp_vld) begin ok = 1; break; end
    end
    chk("latency", lat, elat);
    if (!ok) return;
    if (bp > 0) begin
      d0 = bif.rsp_dat; e0 = bif.rsp_err;
      // a competing command must not be taken while the response stalls
      @(posedge clk); #1;
      bif.cmd_vld = 1'b1; bif.cmd_op = 2'b01; bif.cmd_dat = $urandom;
      repeat (bp) begin
        @(negedge clk);
        chk("bp_vld", bif.rsp_vld, 1);
        chk("bp_dat", bif.rsp_dat, d0);
        chk("bp_err", bif.rsp_err, e0);
        chk("bp_cmd_rdy", bif.cmd_rdy, 0);
        chk("bp_cnt", cnt, model.size());
      end
      @(posedge clk); #1;
      bif.cmd_vld = 1'b0; bif.rsp_rdy = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    chk("cmd_rdy_after_rsp", bif.cmd_rdy, 1);
    chk("rsp_vld_after_rsp", bif.rsp_vld, 0);
  endtask

  initial begin
    logic [1:0] op;
    int r;
    bif.cmd_vld = 1'b0; bif.cmd_op = 2'b00; bif.cmd_dat = '0; bif.rsp_rdy = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;

    // reset and idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cnt", cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_cmd_rdy", bif.cmd_rdy, 1);
    chk("rst_rsp_vld", bif.rsp_vld, 0);
    chk("rst_rsp_dat", bif.rsp_dat, 0);
    chk("rst_rsp_err", bif.rsp_err, 0);
    chk("rst_ram_en", ram_en, 0);

    // push then pop
    issue(2'b01, 32'hA5A5_0001, 0);
    issue(2'b01, 32'h0000_0002, 0);
    issue(2'b10, '0, 0);
    issue(2'b10, '0, 0);

    // full and empty errors
    for (int i = 0; i < N + 1; i++) issue(2'b01, $urandom, 0);
    issue(2'b11, '0, 0);
    issue(2'b10, '0, 0);

    // backpressure on a pop response
    issue(2'b01, 32'hDEAD_BEEF, 0);
    issue(2'b10, '0, 5);

    // illegal opcode
    issue(2'b01, 32'h1234_5678, 0);
    issue(2'b00, $urandom, 0);

    // reset in the POP_WAIT cycle
    @(posedge clk); #1;
    bif.cmd_vld = 1'b1; bif.cmd_op = 2'b10; bif.rsp_rdy = 1'b1;
    @(negedge clk);
    chk("midpop_accept", bif.cmd_rdy && ram_en, 1);
    @(posedge clk); #1;
    bif.cmd_vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model.delete();
    @(negedge clk);
    chk("midpop_rsp_vld", bif.rsp_vld, 0);
    chk("midpop_cnt", cnt, 0);
    chk("midpop_cmd_rdy", bif.cmd_rdy, 1);
    issue(2'b10, '0, 0);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
      issue(op, $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/stk_ram_ctrl.md
# stk_ram_ctrl

LIFO stack engine that presents a command/response interface upstream and drives a single-port synchronous RAM downstream. It is the initiator side of the simulation RAM models in `tech/sim/rams`. It issues the RAM reads and writes that those models answer, so a stack of depth `N` lives in RAM rather than in flops. One command is in flight at a time. Every accepted command returns exactly one response.

## Interface
Parameters:
- `W`, 32, data width in bits.
- `N`, 256, stack depth; must be a power of two and ≥ 2.
- `AW`, `$clog2(N)`, RAM address width (derived, not overridden).

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_vld`  in  1  command valid.
- `cmd_op`  in  2  command opcode: 2'b01 PUSH, 2'b10 POP, 2'b11 CLEAR, 2'b00 illegal.
- `cmd_dat`  in  W  push data.
- `cmd_rdy`  out  1  command ready.
- `rsp_vld`  out  1  response valid.
- `rsp_rdy`  in  1  response ready.
- `rsp_dat`  out  W  popped data; 0 for every other response.
- `rsp_err`  out  1  command rejected.
- `ram_en`  out  1  RAM access strobe.
- `ram_wen`  out  1  RAM write enable; qualified by `ram_en`.
- `ram_addr`  out  AW  RAM address.
- `ram_din`  out  W  RAM write data.
- `ram_dout`  in  W  RAM read data, valid the cycle after a read strobe.
- `cnt`  out  AW+1  occupancy, 0..N.
- `full`  out  1  `cnt == N`.
- `empty`  out  1  `cnt == 0`.

## Operation
- FSM states are IDLE, POP_WAIT and RSP. Reset state is IDLE.
- `cmd_rdy` = (state == IDLE). A command is accepted in the cycle where `cmd_vld & cmd_rdy`; call it cycle T.

Command handling in cycle T:
- PUSH, not full:
  - Drive `ram_en=1`, `ram_wen=1`, `ram_addr=cnt[AW-1:0]`, `ram_din=cmd_dat`, combinationally in T.
  - `cnt` increments at T+1. Next state RSP with `rsp_err=0`, `rsp_dat=0`.
- POP, not empty:
  - Drive `ram_en=1`, `ram_wen=0`, `ram_addr=cnt-1`, combinationally in T.
  - Next state POP_WAIT. `cnt` decrements at T+1.
  - In POP_WAIT, register `ram_dout` into `rsp_dat`. Next state RSP with `rsp_err=0`.
- CLEAR: `cnt` goes to 0 at T+1, with no RAM access. Next state RSP with `rsp_err=0`.
- PUSH when full, POP when empty, or opcode 2'b00:
  - No RAM access and `cnt` is unchanged.
  - Next state RSP with `rsp_err=1`, `rsp_dat=0`.

Response and RAM rules:
- RSP: `rsp_vld=1`. `rsp_dat` and `rsp_err` stay stable until `rsp_vld & rsp_rdy`, then the FSM returns to IDLE on the next cycle.
- The RAM is driven only in the accept cycle. `ram_en=0` in all other cycles. `ram_addr` and `ram_din` are don't-care when `ram_en=0` but are driven to 0.
- Address arithmetic uses `cnt[AW-1:0]`. A PUSH at `cnt=N-1` writes address N-1, and `cnt` becomes N with `full=1`.
- `cnt` saturates: it can never exceed N or drop below 0, because the full/empty checks prevent it.

## Timing
- Reset (synchronous) forces state IDLE and zeroes all registered outputs.
  - Output values on reset: `cnt=0`, `empty=1`, `full=0`, `cmd_rdy=1`, `rsp_vld=0`, `rsp_dat=0`, `rsp_err=0`, `ram_en=0`.
  - Reset mid-operation (in POP_WAIT or RSP) discards the pending response. RAM contents are left untouched but are logically lost.
- Latency from acceptance to `rsp_vld`:
  - PUSH, CLEAR and error responses: 1 cycle.
  - POP: 2 cycles.
- Throughput with `rsp_rdy` held high: one PUSH every 2 cycles, one POP every 3 cycles.
- `rsp_rdy` may be high before `rsp_vld`; there is no combinational path from `rsp_rdy` to `cmd_rdy`.
- A `cmd_vld` that is raised while `cmd_rdy=0` must be held by the sender with stable `cmd_op` and `cmd_dat`. The block samples the command only in IDLE.
- `cnt`, `full` and `empty` are registered and reflect the updated occupancy from T+1.

## Test plan
- Reset and idle: assert `rst` for 2 cycles, then release.
  - Required: `cnt=0`, `empty=1`, `cmd_rdy=1`, `rsp_vld=0`, and `ram_en` never high.
- Push then pop:
  - PUSH 0xA5A5_0001, then PUSH 0x0000_0002. Required: writes to address 0, then address 1.
  - POP, POP. Required: `rsp_dat` of 0x2 then 0xA5A5_0001, each 2 cycles after acceptance, `rsp_err=0`, and `cnt` ending at 0.
- Full and empty errors:
  - With `N=4`, push 4 values, then a 5th PUSH. Required: `rsp_err=1`, no `ram_en`, `cnt=4`.
  - CLEAR, then POP. Required: `rsp_err=1`, `rsp_dat=0`, `cnt=0`.
- Backpressure: hold `rsp_rdy=0` for 5 cycles during a POP response.
  - Required: `rsp_vld`, `rsp_dat` and `rsp_err` stay stable, `cmd_rdy` stays 0, and no second command is accepted.
- Illegal opcode: issue `cmd_op=2'b00`.
  - Required: `rsp_err=1` 1 cycle after acceptance, `cnt` unchanged.
- Reset mid-pop: assert `rst` in the POP_WAIT cycle.
  - Required: next cycle `rsp_vld=0`, `cnt=0`, `cmd_rdy=1`.
  - A following POP returns `rsp_err=1`.
